// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: single clock domain with an internal pixel-tick enable.
// Presents (h,v) decode on registered sync/enable/value outputs plus line/frame strobes.
module vga_timing_gen #(
  parameter int unsigned CLK_DIV  = 4,
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          H_POL    = 1'b0,
  parameter bit          V_POL    = 1'b0,
  parameter int unsigned CNT_W    = 10,
  parameter int unsigned FRAME_W  = 8
) (
  input  logic               Master_Clock_In,
  input  logic               Reset_N_In,
  output logic               Pix_Tick_Out,
  output logic               Sync_Horiz_Out,
  output logic               Sync_Vert_Out,
  output logic               Disp_Ena_Out,
  output logic [CNT_W-1:0]   Val_Col_Out,
  output logic [CNT_W-1:0]   Val_Row_Out,
  output logic               Line_Start_Out,
  output logic               Frame_Start_Out,
  output logic [FRAME_W-1:0] Frame_Count_Out
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] H_SS     = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] H_SE     = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] V_SS     = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] V_SE     = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [DIV_W-1:0]   div_q, div_d;
  logic [CNT_W-1:0]   h_q, h_d, v_q, v_d;
  logic [CNT_W-1:0]   col_q, col_d, row_q, row_d;
  logic               de_q, de_d, hs_q, hs_d, vs_q, vs_d;
  logic               ls_q, ls_d, fs_q, fs_d;
  logic [FRAME_W-1:0] fc_q, fc_d;
  logic               first_q, first_d;
  logic               tick, visible, h_act, v_act, at_origin;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    visible   = (h_q < H_VIS) && (v_q < V_VIS);
    h_act     = (h_q >= H_SS) && (h_q < H_SE);
    v_act     = (v_q >= V_SS) && (v_q < V_SE);
    at_origin = (h_q == '0) && (v_q == '0);

    div_d   = tick ? '0 : div_q + DIV_W'(1);
    h_d     = h_q;
    v_d     = v_q;
    de_d    = de_q;
    col_d   = col_q;
    row_d   = row_q;
    hs_d    = hs_q;
    vs_d    = vs_q;
    ls_d    = 1'b0;
    fs_d    = 1'b0;
    fc_d    = fc_q;
    first_d = first_q;

    if (tick) begin
      de_d  = visible;
      col_d = visible ? h_q : '0;
      row_d = visible ? v_q : '0;
      hs_d  = h_act ? H_POL : ~H_POL;
      vs_d  = v_act ? V_POL : ~V_POL;
      ls_d  = (h_q == '0);
      fs_d  = at_origin;
      // The first origin after reset starts frame 0 rather than completing one.
      if (at_origin) begin
        if (first_q) begin
          first_d = 1'b0;
        end else begin
          fc_d = fc_q + FRAME_W'(1);
        end
      end
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + CNT_W'(1);
      end else begin
        h_d = h_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge Master_Clock_In) begin
    if (!Reset_N_In) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      de_q    <= 1'b0;
      col_q   <= '0;
      row_q   <= '0;
      hs_q    <= ~H_POL;
      vs_q    <= ~V_POL;
      ls_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      first_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      de_q    <= de_d;
      col_q   <= col_d;
      row_q   <= row_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      ls_q    <= ls_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
      first_q <= first_d;
    end
  end

  assign Pix_Tick_Out    = tick;
  assign Sync_Horiz_Out  = hs_q;
  assign Sync_Vert_Out   = vs_q;
  assign Disp_Ena_Out    = de_q;
  assign Val_Col_Out     = col_q;
  assign Val_Row_Out     = row_q;
  assign Line_Start_Out  = ls_q;
  assign Frame_Start_Out = fs_q;
  assign Frame_Count_Out = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: four parameterisations checked every cycle against a closed-form
// raster model, plus fixed vectors and aggregate line/frame measurements.
module tb_vga_timing_gen;

  typedef struct packed {
    logic [31:0] tick, hs, vs, de, col, row, ls, fs, fc;
  } exp_t;

  typedef struct {
    int unsigned d, ha, hf, hsw, hb, va, vf, vsw, vb, hp, vp, fw;
  } cfg_t;

  typedef struct {
    int unsigned inst;
    int unsigned cyc;
    exp_t        e;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       u0_tick, u0_hs, u0_vs, u0_de, u0_ls, u0_fs;
  logic [9:0] u0_col, u0_row;
  logic [7:0] u0_fc;
  logic       u1_tick, u1_hs, u1_vs, u1_de, u1_ls, u1_fs;
  logic [9:0] u1_col, u1_row;
  logic [1:0] u1_fc;
  logic       u2_tick, u2_hs, u2_vs, u2_de, u2_ls, u2_fs;
  logic [9:0] u2_col, u2_row;
  logic [2:0] u2_fc;
  logic       u3_tick, u3_hs, u3_vs, u3_de, u3_ls, u3_fs;
  logic [9:0] u3_col, u3_row;
  logic [7:0] u3_fc;

  vga_timing_gen u0 (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Pix_Tick_Out(u0_tick),
    .Sync_Horiz_Out(u0_hs), .Sync_Vert_Out(u0_vs), .Disp_Ena_Out(u0_de),
    .Val_Col_Out(u0_col), .Val_Row_Out(u0_row), .Line_Start_Out(u0_ls),
    .Frame_Start_Out(u0_fs), .Frame_Count_Out(u0_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(1), .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_POL(1'b1), .V_POL(1'b1), .FRAME_W(2)
  ) u1 (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Pix_Tick_Out(u1_tick),
    .Sync_Horiz_Out(u1_hs), .Sync_Vert_Out(u1_vs), .Disp_Ena_Out(u1_de),
    .Val_Col_Out(u1_col), .Val_Row_Out(u1_row), .Line_Start_Out(u1_ls),
    .Frame_Start_Out(u1_fs), .Frame_Count_Out(u1_fc)
  );

  vga_timing_gen #(
    .CLK_DIV(3), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .FRAME_W(3)
  ) u2 (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Pix_Tick_Out(u2_tick),
    .Sync_Horiz_Out(u2_hs), .Sync_Vert_Out(u2_vs), .Disp_Ena_Out(u2_de),
    .Val_Col_Out(u2_col), .Val_Row_Out(u2_row), .Line_Start_Out(u2_ls),
    .Frame_Start_Out(u2_fs), .Frame_Count_Out(u2_fc)
  );

  vga_timing_gen #(.CLK_DIV(1)) u3 (
    .Master_Clock_In(clk), .Reset_N_In(rst_n), .Pix_Tick_Out(u3_tick),
    .Sync_Horiz_Out(u3_hs), .Sync_Vert_Out(u3_vs), .Disp_Ena_Out(u3_de),
    .Val_Col_Out(u3_col), .Val_Row_Out(u3_row), .Line_Start_Out(u3_ls),
    .Frame_Start_Out(u3_fs), .Frame_Count_Out(u3_fc)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned c = 0;
  bit          phase1 = 1'b0;
  cfg_t        cfg[4];
  vec_t        vec[$];

  int unsigned de0_cnt = 0, hs0_low = 0, hs0_first = 0;
  int unsigned fs2_cyc[$];
  int unsigned ls2_cnt = 0, vs2_low_lines = 0;
  int unsigned fs1_cyc[$];
  int unsigned fc1_seen[$];

  function automatic exp_t mk(int unsigned tick, int unsigned hs, int unsigned vs,
                              int unsigned de, int unsigned col, int unsigned row,
                              int unsigned ls, int unsigned fs, int unsigned fc);
    exp_t e;
    e.tick = tick; e.hs = hs; e.vs = vs; e.de = de; e.col = col;
    e.row = row; e.ls = ls; e.fs = fs; e.fc = fc;
    return e;
  endfunction

  // Cycle c counts released edges since the last reset edge; pixel p is shown from c = d*(p+1).
  function automatic exp_t model(cfg_t g, int unsigned cyc);
    exp_t e;
    int unsigned ht, vt, p, ph, h, v;
    ht = g.ha + g.hf + g.hsw + g.hb;
    vt = g.va + g.vf + g.vsw + g.vb;
    e = '0;
    e.tick = ((cyc % g.d) == g.d - 1) ? 1 : 0;
    if (cyc < g.d) begin
      e.hs = 1 - g.hp;
      e.vs = 1 - g.vp;
    end else begin
      p  = (cyc - g.d) / g.d;
      ph = (cyc - g.d) % g.d;
      h  = p % ht;
      v  = (p / ht) % vt;
      e.de  = (h < g.ha && v < g.va) ? 1 : 0;
      e.col = (e.de != 0) ? h : 0;
      e.row = (e.de != 0) ? v : 0;
      e.hs  = (h >= g.ha + g.hf && h < g.ha + g.hf + g.hsw) ? g.hp : 1 - g.hp;
      e.vs  = (v >= g.va + g.vf && v < g.va + g.vf + g.vsw) ? g.vp : 1 - g.vp;
      e.ls  = (ph == 0 && h == 0) ? 1 : 0;
      e.fs  = (ph == 0 && h == 0 && v == 0) ? 1 : 0;
      e.fc  = (p / (ht * vt)) % (32'd1 << g.fw);
    end
    return e;
  endfunction

  task automatic check_out(string name, exp_t act, exp_t exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got tick=%0d hs=%0d vs=%0d de=%0d col=%0d row=%0d ls=%0d fs=%0d fc=%0d, want tick=%0d hs=%0d vs=%0d de=%0d col=%0d row=%0d ls=%0d fs=%0d fc=%0d",
               name, c, act.tick, act.hs, act.vs, act.de, act.col, act.row, act.ls, act.fs,
               act.fc, exp.tick, exp.hs, exp.vs, exp.de, exp.col, exp.row, exp.ls, exp.fs,
               exp.fc);
    end
  endtask

  task automatic check_val(string name, int unsigned act, int unsigned exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic step();
    exp_t act[4];
    @(posedge clk);
    if (!rst_n) c = 0;
    else c++;
    @(negedge clk);
    act[0] = mk(32'(u0_tick), 32'(u0_hs), 32'(u0_vs), 32'(u0_de), 32'(u0_col), 32'(u0_row),
                32'(u0_ls), 32'(u0_fs), 32'(u0_fc));
    act[1] = mk(32'(u1_tick), 32'(u1_hs), 32'(u1_vs), 32'(u1_de), 32'(u1_col), 32'(u1_row),
                32'(u1_ls), 32'(u1_fs), 32'(u1_fc));
    act[2] = mk(32'(u2_tick), 32'(u2_hs), 32'(u2_vs), 32'(u2_de), 32'(u2_col), 32'(u2_row),
                32'(u2_ls), 32'(u2_fs), 32'(u2_fc));
    act[3] = mk(32'(u3_tick), 32'(u3_hs), 32'(u3_vs), 32'(u3_de), 32'(u3_col), 32'(u3_row),
                32'(u3_ls), 32'(u3_fs), 32'(u3_fc));
    check_out("model_u0", act[0], model(cfg[0], c));
    check_out("model_u1", act[1], model(cfg[1], c));
    check_out("model_u2", act[2], model(cfg[2], c));
    check_out("model_u3", act[3], model(cfg[3], c));
    foreach (vec[i]) begin
      if (vec[i].cyc == c) check_out($sformatf("vec%0d_u%0d", i, vec[i].inst),
                                     act[vec[i].inst], vec[i].e);
    end
    if (phase1) begin
      if (c >= 4 && c < 3204) begin
        if (u0_de) de0_cnt++;
        if (!u0_hs) begin
          if (hs0_low == 0) hs0_first = c;
          hs0_low++;
        end
      end
      if (u2_fs) fs2_cyc.push_back(c);
      if (u2_ls && fs2_cyc.size() == 1) begin
        ls2_cnt++;
        if (!u2_vs) vs2_low_lines++;
      end
      if (u1_fs) begin
        fs1_cyc.push_back(c);
        fc1_seen.push_back(32'(u1_fc));
      end
    end
  endtask

  task automatic run(int unsigned n);
    for (int unsigned k = 0; k < n && n_fail <= 40; k++) step();
  endtask

  initial begin
    int unsigned fc_exp[5];
    fc_exp = '{0, 1, 2, 3, 0};
    cfg[0] = '{d:4, ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, hp:0, vp:0, fw:8};
    cfg[1] = '{d:1, ha:4, hf:1, hsw:1, hb:1, va:2, vf:1, vsw:1, vb:1, hp:1, vp:1, fw:2};
    cfg[2] = '{d:3, ha:8, hf:2, hsw:3, hb:2, va:6, vf:2, vsw:2, vb:3, hp:0, vp:0, fw:3};
    cfg[3] = '{d:1, ha:640, hf:16, hsw:96, hb:48, va:480, vf:10, vsw:2, vb:33, hp:0, vp:0, fw:8};

    //                       tick hs vs de col row ls fs fc
    vec.push_back('{0, 0,    mk(0, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 3,    mk(1, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 4,    mk(0, 1, 1, 1, 0,   0, 1, 1, 0)});
    vec.push_back('{0, 5,    mk(0, 1, 1, 1, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 7,    mk(1, 1, 1, 1, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 8,    mk(0, 1, 1, 1, 1,   0, 0, 0, 0)});
    vec.push_back('{0, 2560, mk(0, 1, 1, 1, 639, 0, 0, 0, 0)});
    vec.push_back('{0, 2564, mk(0, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 2627, mk(1, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 2628, mk(0, 0, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 3011, mk(1, 0, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 3012, mk(0, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{0, 3204, mk(0, 1, 1, 1, 0,   1, 1, 0, 0)});
    vec.push_back('{3, 0,    mk(1, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{3, 1,    mk(1, 1, 1, 1, 0,   0, 1, 1, 0)});
    vec.push_back('{3, 2,    mk(1, 1, 1, 1, 1,   0, 0, 0, 0)});
    vec.push_back('{3, 640,  mk(1, 1, 1, 1, 639, 0, 0, 0, 0)});
    vec.push_back('{3, 641,  mk(1, 1, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{3, 657,  mk(1, 0, 1, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{3, 801,  mk(1, 1, 1, 1, 0,   1, 1, 0, 0)});
    vec.push_back('{1, 0,    mk(1, 0, 0, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{1, 6,    mk(1, 1, 0, 0, 0,   0, 0, 0, 0)});
    vec.push_back('{1, 22,   mk(1, 0, 1, 0, 0,   0, 1, 0, 0)});
    vec.push_back('{1, 36,   mk(1, 0, 0, 1, 0,   0, 1, 1, 1)});

    rst_n = 1'b0;
    run(5);
    rst_n = 1'b1;
    phase1 = 1'b1;
    run(3400);
    phase1 = 1'b0;

    check_val("u0_row0_de_clocks", de0_cnt, 2560);
    check_val("u0_row0_hsync_low_clocks", hs0_low, 384);
    check_val("u0_row0_hsync_first_low", hs0_first, 2628);
    check_val("u2_lines_per_frame", ls2_cnt, 13);
    check_val("u2_vsync_low_lines", vs2_low_lines, 2);
    if (fs2_cyc.size() >= 2) check_val("u2_frame_period", fs2_cyc[1] - fs2_cyc[0], 585);
    else check_val("u2_frames_seen", fs2_cyc.size(), 2);
    if (fs1_cyc.size() >= 2) check_val("u1_frame_period", fs1_cyc[1] - fs1_cyc[0], 35);
    else check_val("u1_frames_seen", fs1_cyc.size(), 2);
    for (int i = 0; i < 5; i++) begin
      if (i < fc1_seen.size()) check_val($sformatf("u1_frame_count_%0d", i), fc1_seen[i],
                                         fc_exp[i]);
      else check_val("u1_frame_count_missing", fc1_seen.size(), 5);
    end

    // Mid-line reset with u0 presenting column 300, then a clean restart.
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(1206);
    check_val("u0_col_before_reset", 32'(u0_col), 300);
    rst_n = 1'b0;
    run(1);
    rst_n = 1'b1;
    run(3300);

    for (int it = 0; it < 8 && n_fail <= 40; it++) begin
      run($urandom_range(20, 2500));
      rst_n = 1'b0;
      run($urandom_range(1, 3));
      rst_n = 1'b1;
    end
    run(50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator. It replaces the separate clock-divider and fixed 640x480 controller pair with a single-clock block that uses an internal pixel-tick enable. Resolution, porches, sync widths, sync polarity and divide ratio are parameters. It adds line/frame strobes and a frame counter for the draw logic downstream. It sits between the board clock and the pixel-drawing block.

## Interface

Parameters:
- CLK_DIV, 4: system clocks per pixel (>=1); 100 MHz / 4 = 25 MHz pixel rate
- H_ACTIVE, 640: visible columns
- H_FP, 16: horizontal front porch, pixels
- H_SYNC, 96: horizontal sync width, pixels
- H_BP, 48: horizontal back porch, pixels
- V_ACTIVE, 480: visible rows
- V_FP, 10: vertical front porch, lines
- V_SYNC, 2: vertical sync width, lines
- V_BP, 33: vertical back porch, lines
- H_POL, 0: active level of Sync_Horiz_Out (0 = active-low)
- V_POL, 0: active level of Sync_Vert_Out
- CNT_W, 10: column/row counter width; must hold H_TOTAL-1 and V_TOTAL-1
- FRAME_W, 8: frame counter width

Ports:
- Master_Clock_In  in  1  system clock; all logic on rising edge
- Reset_N_In  in  1  synchronous, active-low reset
- Pix_Tick_Out  out  1  one-cycle strobe, high when divider = CLK_DIV-1
- Sync_Horiz_Out  out  1  horizontal sync
- Sync_Vert_Out  out  1  vertical sync
- Disp_Ena_Out  out  1  high while the presented pixel is visible
- Val_Col_Out  out  CNT_W  visible column, 0 when blanked
- Val_Row_Out  out  CNT_W  visible row, 0 when blanked
- Line_Start_Out  out  1  one-cycle pulse when the presented column becomes 0
- Frame_Start_Out  out  1  one-cycle pulse when the presented pixel becomes (0,0)
- Frame_Count_Out  out  FRAME_W  completed frames since reset, modulo 2^FRAME_W

## Operation

- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider `div` counts 0..CLK_DIV-1, wraps. Pix_Tick_Out = (div == CLK_DIV-1). With CLK_DIV=1 it is high every cycle.
- Position counters `h`, `v` hold the next pixel to present. Reset value is (0,0).
- On a tick edge, the registered outputs load the decode of (h,v). Then h advances. At h = H_TOTAL-1, h wraps to 0 and v advances. At v = V_TOTAL-1 with h wrapping, v wraps to 0.
- Decode of (h,v):
  - Disp_Ena = h<H_ACTIVE && v<V_ACTIVE.
  - Val_Col = Disp_Ena ? h : 0.
  - Val_Row = Disp_Ena ? v : 0.
  - Hsync active (=H_POL) when H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC; otherwise ~H_POL.
  - Vsync active (=V_POL) when V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for the whole line; otherwise ~V_POL.
- Line_Start_Out is high for exactly one clock, on the edge that loads h=0. Frame_Start_Out is high for exactly one clock, on the edge that loads (0,0). Both are low on all other cycles, including the remaining CLK_DIV-1 cycles of that pixel.
- Frame_Count_Out increments on each Frame_Start except the first after reset. It therefore reads 1 during the second frame. It wraps 2^FRAME_W-1 -> 0.
- Reset values, applied on any edge with Reset_N_In=0, including mid-frame:
  - div=0, h=v=0.
  - Disp_Ena_Out=0, Val_Col_Out=Val_Row_Out=0.
  - Sync_Horiz_Out=~H_POL, Sync_Vert_Out=~V_POL.
  - Pix_Tick_Out=0 (1 if CLK_DIV=1), Line_Start_Out=Frame_Start_Out=0, Frame_Count_Out=0.
  - A "first frame" flag is set so that the next Frame_Start does not increment the count.

## Timing

- Cycle 0 is the first edge with Reset_N_In=1.
- Pix_Tick_Out is high in cycles CLK_DIV-1, 2·CLK_DIV-1, and so on.
- Pixel (0,0) is presented from cycle CLK_DIV. Line_Start_Out and Frame_Start_Out are high in cycle CLK_DIV only.
- Every presented pixel is held for exactly CLK_DIV cycles.
- A line is H_TOTAL·CLK_DIV cycles. A frame is H_TOTAL·V_TOTAL·CLK_DIV cycles (1,680,000 at defaults).
- All outputs except Pix_Tick_Out are registered and change only on the edge following a tick. Sync, enable and value outputs are mutually aligned with zero skew.

## Test plan

- Reset hold, then release at defaults: all outputs at reset values. Pix_Tick_Out first high in cycle 3. Frame_Start_Out and Line_Start_Out pulse in cycle 4, with Disp_Ena_Out=1, Val_Col_Out=0, Val_Row_Out=0.
- Defaults, row 0:
  - Disp_Ena_Out is high for columns 0..639 and low for columns 640..799.
  - Sync_Horiz_Out is low for exactly 96 pixels (384 clocks), starting at column 656.
  - Val_Col_Out = 639 on the last visible pixel, then 0.
- Defaults, vertical: Sync_Vert_Out is low for lines 490 and 491 only. Line_Start_Out pulses 525 times per frame. The frame period is 1,680,000 clocks.
- Tiny config, H=4/1/1/1, V=2/1/1/1, CLK_DIV=1, FRAME_W=2, H_POL=V_POL=1:
  - Frame is 35 cycles.
  - Frame_Count_Out reads 0,1,2,3,0 across frames 1..5.
  - Syncs are active-high at column 5 and row 3.
- Reset asserted mid-frame at defaults, e.g. at column 300, row 200: outputs return to reset values on the next edge. After release the (0,0) timing is identical to the first scenario, and Frame_Count_Out=0.
- CLK_DIV=1 with default timing: Pix_Tick_Out is constantly high, every pixel lasts one clock, and pixel (0,0) is presented from cycle 1.
